// File: rtl/mux4_param_if.sv
// Bus bundle for mux4_param: four WIDTH-bit operands, a 2-bit select and a valid qualifier in,
// the combinational selection plus its registered copy and valid out.
interface mux4_param_if #(
    parameter int WIDTH = 4
);
    // Valid-only handshake: in_valid qualifies a..d/s in the cycle it is high. There is no ready,
    // so a result is taken every valid cycle. out_valid marks the cycle y_q holds a capture.
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;

    modport master (
        output in_valid, a, b, c, d, s,
        input  y, y_q, out_valid
    );

    modport slave (
        input  in_valid, a, b, c, d, s,
        output y, y_q, out_valid
    );
endinterface

// File: rtl/mux4_param.sv
// Parameterized 4:1 word multiplexer with a zero-latency output y and an optional
// one-stage registered copy y_q/out_valid for timing-critical consumers.
module mux4_param #(
    parameter int WIDTH   = 4,
    parameter bit OUT_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mux4_param_if.slave  bus
);
    logic [WIDTH-1:0] w_y;

    // An unknown select must propagate as unknown rather than fall back to an operand.
    always_comb begin
        case (bus.s)
            2'b00:   w_y = bus.a;
            2'b01:   w_y = bus.b;
            2'b10:   w_y = bus.c;
            2'b11:   w_y = bus.d;
            default: w_y = 'x;
        endcase
    end

    assign bus.y = w_y;

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] r_y_q;
            logic             r_out_valid;

            // y_q holds its last capture on idle cycles; only out_valid drops.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_y_q       <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    if (bus.in_valid) begin
                        r_y_q <= w_y;
                    end
                    r_out_valid <= bus.in_valid;
                end
            end

            assign bus.y_q       = r_y_q;
            assign bus.out_valid = r_out_valid;
        end else begin : g_out_comb
            assign bus.y_q       = w_y;
            assign bus.out_valid = bus.in_valid & rst_n;
        end
    endgenerate
endmodule

// File: tb/tb_mux4_param.sv
// Directed plus randomized bench for mux4_param: a registered WIDTH=4 instance and a
// combinational WIDTH=16 instance checked against a select-by-index reference model.
module tb_mux4_param;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Expected y_q captures pending for the next edge, plus the currently expected registered state.
    logic [3:0] exp_q[$];
    logic [3:0] m_yq;
    logic       m_ov;

    mux4_param_if #(.WIDTH(4))  bus4 ();
    mux4_param_if #(.WIDTH(16)) bus16 ();

    mux4_param #(.WIDTH(4), .OUT_REG(1'b1)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux4_param #(.WIDTH(16), .OUT_REG(1'b0)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference: the operand picked by a 2-bit index into {a, b, c, d}.
    function automatic logic [31:0] ref_sel(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d,
                                            input logic [1:0] s);
        logic [31:0] ops [4];
        ops[0] = a;
        ops[1] = b;
        ops[2] = c;
        ops[3] = d;
        return ops[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Same-cycle outputs of both instances.
    task automatic check_comb();
        logic [31:0] e4;
        logic [31:0] e16;
        e4  = ref_sel(32'(bus4.a), 32'(bus4.b), 32'(bus4.c), 32'(bus4.d), bus4.s);
        e16 = ref_sel(32'(bus16.a), 32'(bus16.b), 32'(bus16.c), 32'(bus16.d), bus16.s);
        chk("y4", 32'(bus4.y), e4);
        chk("y16", 32'(bus16.y), e16);
        chk("y_q16", 32'(bus16.y_q), e16);
        chk("out_valid16", 32'(bus16.out_valid), 32'(bus16.in_valid & rst_n));
    endtask

    // One rising edge: the model decides what the edge should do from the inputs held across it,
    // then the registered outputs are checked 1 ns after the edge.
    task automatic tick();
        if (!rst_n) begin
            exp_q.delete();
            m_yq = '0;
            m_ov = 1'b0;
        end else if (bus4.in_valid) begin
            exp_q.push_back(4'(ref_sel(32'(bus4.a), 32'(bus4.b), 32'(bus4.c), 32'(bus4.d), bus4.s)));
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                m_yq = exp_q.pop_front();
                m_ov = 1'b1;
            end else begin
                m_ov = 1'b0;
            end
        end
        chk("y_q4", 32'(bus4.y_q), 32'(m_yq));
        chk("out_valid4", 32'(bus4.out_valid), 32'(m_ov));
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d, input logic [1:0] s);
        bus4.in_valid = v;
        bus4.a = a;
        bus4.b = b;
        bus4.c = c;
        bus4.d = d;
        bus4.s = s;
    endtask

    initial begin
        rst_n = 1'b0;
        m_yq  = '0;
        m_ov  = 1'b0;
        drive4(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        bus16.in_valid = 1'b0;
        bus16.a = '0;
        bus16.b = '0;
        bus16.c = '0;
        bus16.d = '0;
        bus16.s = '0;

        // Reset held for two edges with a valid capture pending: y follows a, y_q stays 0.
        @(posedge clk);
        #1;
        drive4(1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 2'd0);
        #1;
        check_comb();
        chk("y_during_reset", 32'(bus4.y), 32'd5);
        tick();
        tick();
        chk("reset_y_q", 32'(bus4.y_q), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("release_y_q", 32'(bus4.y_q), 32'd5);
        chk("release_out_valid", 32'(bus4.out_valid), 32'd1);

        // Step s through 0..3 inside one cycle; y follows each step.
        drive4(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
        for (int i = 0; i < 4; i++) begin
            bus4.s = 2'(i);
            #1;
            check_comb();
            chk("y_step", 32'(bus4.y), 32'(i + 1));
        end
        tick();

        // Back-to-back valid: one capture per edge, then hold with out_valid low.
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 2'(i));
            tick();
            chk("b2b_y_q", 32'(bus4.y_q), 32'(i + 1));
        end
        bus4.in_valid = 1'b0;
        tick();
        chk("hold_y_q", 32'(bus4.y_q), 32'd4);
        chk("hold_out_valid", 32'(bus4.out_valid), 32'd0);

        // Mid-cycle operand change: y moves at once, y_q only on the next valid edge.
        bus4.s = 2'd2;
        #1;
        chk("c3_y", 32'(bus4.y), 32'd3);
        bus4.c = 4'd9;
        #1;
        chk("c9_y", 32'(bus4.y), 32'd9);
        chk("c9_y_q_unchanged", 32'(bus4.y_q), 32'd4);
        bus4.in_valid = 1'b1;
        tick();
        chk("c9_y_q", 32'(bus4.y_q), 32'd9);

        // One-cycle reset inside a valid stream.
        drive4(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 2'd1);
        tick();
        rst_n = 1'b0;
        bus4.s = 2'd2;
        tick();
        chk("midrst_y_q", 32'(bus4.y_q), 32'd0);
        rst_n = 1'b1;
        bus4.s = 2'd3;
        tick();
        chk("resume_y_q", 32'(bus4.y_q), 32'd4);

        // Combinational instance: same-cycle copy.
        bus16.a = 16'hA5A5;
        bus16.d = 16'hFFFF;
        bus16.s = 2'd3;
        bus16.in_valid = 1'b1;
        #1;
        check_comb();
        chk("w16_y", 32'(bus16.y), 32'h0000FFFF);
        chk("w16_y_q", 32'(bus16.y_q), 32'h0000FFFF);
        chk("w16_out_valid", 32'(bus16.out_valid), 32'd1);
        tick();

        // Randomized traffic with occasional resets on both instances.
        for (int n = 0; n < 200; n++) begin
            rst_n = ($urandom_range(0, 9) != 0);
            drive4(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 2'($urandom_range(0, 3)));
            bus16.in_valid = 1'($urandom_range(0, 1));
            bus16.a = 16'($urandom);
            bus16.b = 16'($urandom);
            bus16.c = 16'($urandom);
            bus16.d = 16'($urandom);
            bus16.s = 2'($urandom_range(0, 3));
            #1;
            check_comb();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
